multicycle_mips_core: RTL and testbench
=======================================

Name: multicycle_mips_core

Overview:
- Parametrised successor to the single-cycle core: a multi-cycle MIPS-I subset processor with one unified memory port for both instructions and data.
- Uses a valid/ready request handshake, so the bench or a cache can insert wait states.
- Controller FSM and datapath live in one block. Registers: 32x32 register file, PC, IR, A/B latches, ALUOut, MDR.
- Sits at the same level as the single-cycle core and replaces the split inst/data ports.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr and PC. Byte addresses; upper bits are truncated.
- RESET_PC, 0, PC value loaded on reset.
- DATA_WIDTH, 32, word width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1
- mem_addr  out  ADDR_WIDTH  byte address, word aligned
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  request accepted/completed this cycle
- pc  out  ADDR_WIDTH  current PC
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_inst  out  1  sticky flag: unsupported opcode/funct seen

Behaviour:
- Reset (async, nrst=0):
  - state=FETCH, PC=RESET_PC, all GPRs=0, IR=0, illegal_inst=0, retire=0.
  - mem_req=1, mem_we=0 and mem_addr=RESET_PC take effect once nrst is released.
  - Reset mid-operation aborts the instruction; a pending store is dropped.
- Outputs: mem_req, mem_we, mem_addr and mem_wdata are decoded from the state and registers. They hold stable while mem_req=1 and mem_ready=0.
- FSM states: FETCH, DECODE, EXEC, MEM, WB.
  - FETCH: mem_req=1, mem_addr=PC. On the edge with mem_ready=1: IR<=mem_rdata, PC<=PC+4, go to DECODE. Otherwise stay (wait state).
  - DECODE: A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2).
    - j: PC<={PC[top:28], target, 2'b00}, retire, go to FETCH.
    - jal: $31<=PC, then jump as j.
    - jr: PC<=A-source (rs read directly), retire, go to FETCH.
    - All other instructions go to EXEC.
  - EXEC:
    - R-type ALU and addi: ALUOut<=result, go to WB.
    - lw/sw: ALUOut<=A+sext(imm), go to MEM.
    - beq/bne: if the condition holds, PC<=ALUOut. Retire and go to FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut.
    - lw: MDR<=mem_rdata on ready, go to WB.
    - sw: mem_we=1, mem_wdata=B. On ready, retire and go to FETCH.
    - Stay in MEM while mem_ready=0.
  - WB: write rd (R-type), rt (addi) or rt<=MDR (lw). Retire, go to FETCH.
- Supported ops:
  - R-type: add, sub, and, or, slt (signed), sll, srl (shamt field), jr.
  - I-type/J-type: addi, lw, sw, beq, bne, j, jal.
  - add/sub/addi wrap modulo 2^32; no overflow trap.
- Latency with zero wait states:
  - j/jal/jr: 2 cycles
  - beq/bne: 3 cycles
  - R-type/addi/sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle on mem_ready adds 1.
- Register writes to $0 are discarded; reads of $0 return 0.
- Unsupported opcode or funct: treated as NOP. Set illegal_inst, retire in DECODE, go to FETCH.
- Misaligned addresses: low 2 bits of mem_addr are forced to 0.
- PC wraps modulo 2^ADDR_WIDTH.
- retire is high for exactly one cycle, on the final state of each instruction.

Optional Feature:
- Macro: MULTICYCLE_MIPS_PERF_CNT_EN.
- Defined:
  - Adds output cycle_cnt[31:0] (increments every cycle out of reset).
  - Adds output retire_cnt[31:0] (increments on retire).
  - Adds output stall_cnt[31:0] (increments when mem_req=1 and mem_ready=0).
  - All three reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100, memory ready always high. Release nrst → first mem_addr=0x100, mem_req=1, mem_we=0. After addi $1,$0,5 → retire pulses on cycle 4, $1=5.
- addi $2,$0,3; sub $3,$2,$1 (with $1=5) → $3=0xFFFFFFFE. Then slt $4,$3,$2 → $4=1. add $0,$1,$1 → $0 still reads 0.
- sw $1,8($0) then lw $5,8($0), memory inserting 2 wait states per access:
  - sw cycle: mem_we=1, addr=0x8, wdata=5, with mem_addr/mem_wdata held during the waits.
  - Result: $5=5; lw takes 5+4 cycles counting its fetch waits.
- beq $1,$1,-1 at 0x200 → next fetch 0x200. bne $1,$1,+4 → next fetch 0x204. jal 0x400 at 0x300 → $31=0x304, fetch 0x400. jr $31 → fetch 0x304.
- Opcode 0x3F → illegal_inst=1 and stays set, retire pulses, next fetch PC+4. nrst pulsed low during a MEM wait of sw → no write observed, fetch restarts at RESET_PC.
- With MULTICYCLE_MIPS_PERF_CNT_EN: 3 zero-wait R-type instructions → retire_cnt=3, cycle_cnt=12, stall_cnt=0.

Source files
------------

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-I subset core sharing one valid/ready memory port for fetch and data.
// Optional MULTICYCLE_MIPS_PERF_CNT_EN adds cycle_cnt, retire_cnt and stall_cnt outputs.
module multicycle_mips_core #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic                  illegal_inst
`ifdef MULTICYCLE_MIPS_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           retire_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("multicycle_mips_core supports DATA_WIDTH=32 only");
  end

  // ALUOut also carries branch targets, so it must be at least as wide as the PC.
  localparam int unsigned XW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t                r_state, w_nextState;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_ir, r_a, r_b, r_mdr;
  logic [XW-1:0]         r_aluOut;
  logic [31:0]           r_gpr [32];
  logic                  r_illegal;

  logic [5:0]            w_op, w_funct;
  logic [4:0]            w_rs, w_rt, w_rd, w_shamt, w_wbDest;
  logic [15:0]           w_imm;
  logic [31:0]           w_sextImm, w_rsVal, w_rtVal, w_aluResult;
  logic                  w_isRtype, w_isRAlu, w_isJr, w_isJ, w_isJal, w_isAddi;
  logic                  w_isLw, w_isSw, w_isBeq, w_isBne, w_legal, w_isJump, w_taken;
  logic [ADDR_WIDTH-1:0] w_jumpTarget;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_shamt   = r_ir[10:6];
  assign w_funct   = r_ir[5:0];
  assign w_imm     = r_ir[15:0];
  assign w_sextImm = {{16{w_imm[15]}}, w_imm};

  assign w_isRtype = (w_op == OP_RTYPE);
  assign w_isRAlu  = w_isRtype && (w_funct == FN_ADD || w_funct == FN_SUB || w_funct == FN_AND ||
                                   w_funct == FN_OR  || w_funct == FN_SLT || w_funct == FN_SLL ||
                                   w_funct == FN_SRL);
  assign w_isJr    = w_isRtype && (w_funct == FN_JR);
  assign w_isJ     = (w_op == OP_J);
  assign w_isJal   = (w_op == OP_JAL);
  assign w_isAddi  = (w_op == OP_ADDI);
  assign w_isLw    = (w_op == OP_LW);
  assign w_isSw    = (w_op == OP_SW);
  assign w_isBeq   = (w_op == OP_BEQ);
  assign w_isBne   = (w_op == OP_BNE);
  assign w_legal   = w_isRAlu | w_isJr | w_isJ | w_isJal | w_isAddi | w_isLw | w_isSw |
                     w_isBeq | w_isBne;
  assign w_isJump  = w_isJ | w_isJal | w_isJr;
  assign w_taken   = (w_isBeq && (r_a == r_b)) || (w_isBne && (r_a != r_b));
  assign w_wbDest  = w_isRtype ? w_rd : w_rt;

  assign w_rsVal = (w_rs == 5'd0) ? 32'd0 : r_gpr[w_rs];
  assign w_rtVal = (w_rt == 5'd0) ? 32'd0 : r_gpr[w_rt];

  // r_pc already holds PC+4 in DECODE, which is where the region bits come from.
  assign w_jumpTarget = (r_pc & ~ADDR_WIDTH'(32'h0FFF_FFFF)) | ADDR_WIDTH'({r_ir[25:0], 2'b00});

  always_comb begin
    w_aluResult = r_a + r_b;
    if (w_isAddi) begin
      w_aluResult = r_a + w_sextImm;
    end else begin
      unique case (w_funct)
        FN_SUB:  w_aluResult = r_a - r_b;
        FN_AND:  w_aluResult = r_a & r_b;
        FN_OR:   w_aluResult = r_a | r_b;
        FN_SLT:  w_aluResult = {31'd0, ($signed(r_a) < $signed(r_b))};
        FN_SLL:  w_aluResult = r_b << w_shamt;
        FN_SRL:  w_aluResult = r_b >> w_shamt;
        default: w_aluResult = r_a + r_b;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      FETCH:   if (mem_ready) w_nextState = DECODE;
      DECODE:  w_nextState = (!w_legal || w_isJump) ? FETCH : EXEC;
      EXEC: begin
        if (w_isLw || w_isSw)        w_nextState = MEM;
        else if (w_isBeq || w_isBne) w_nextState = FETCH;
        else                         w_nextState = WB;
      end
      MEM:     if (mem_ready) w_nextState = w_isLw ? WB : FETCH;
      WB:      w_nextState = FETCH;
      default: w_nextState = FETCH;
    endcase
  end

  always_comb begin
    mem_req   = (r_state == FETCH) || (r_state == MEM);
    mem_we    = (r_state == MEM) && w_isSw;
    mem_addr  = {r_pc[ADDR_WIDTH-1:2], 2'b00};
    mem_wdata = r_b;
    retire    = 1'b0;
    unique case (r_state)
      DECODE:  retire = !w_legal || w_isJump;
      EXEC:    retire = w_isBeq || w_isBne;
      MEM: begin
        mem_addr = {r_aluOut[ADDR_WIDTH-1:2], 2'b00};
        retire   = w_isSw && mem_ready;
      end
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Datapath registers; reset drops whatever instruction was in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluOut  <= '0;
      r_mdr     <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + ADDR_WIDTH'(4);
          end
        end
        DECODE: begin
          r_a      <= w_rsVal;
          r_b      <= w_rtVal;
          r_aluOut <= XW'(r_pc) + XW'($signed({w_imm, 2'b00}));
          if (!w_legal) begin
            r_illegal <= 1'b1;
          end else if (w_isJ) begin
            r_pc <= w_jumpTarget;
          end else if (w_isJal) begin
            r_gpr[31] <= 32'(r_pc);
            r_pc      <= w_jumpTarget;
          end else if (w_isJr) begin
            r_pc <= ADDR_WIDTH'(w_rsVal);
          end
        end
        EXEC: begin
          if (w_isLw || w_isSw) begin
            r_aluOut <= XW'(r_a + w_sextImm);
          end else if (w_isBeq || w_isBne) begin
            if (w_taken) r_pc <= r_aluOut[ADDR_WIDTH-1:0];
          end else begin
            r_aluOut <= XW'(w_aluResult);
          end
        end
        MEM: begin
          if (mem_ready && w_isLw) r_mdr <= mem_rdata;
        end
        WB: begin
          if (w_wbDest != 5'd0) r_gpr[w_wbDest] <= w_isLw ? r_mdr : r_aluOut[31:0];
        end
        default: ;
      endcase
    end
  end

  assign pc           = r_pc;
  assign illegal_inst = r_illegal;

`ifdef MULTICYCLE_MIPS_PERF_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)                 retire_cnt <= retire_cnt + 32'd1;
      if (mem_req && !mem_ready)  stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Bench for multicycle_mips_core: wait-state memory responder plus an instruction-level
// reference model that predicts latency, PC, stores and the illegal flag at every retire.
`timescale 1ns/1ps
module tb_multicycle_mips_core;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        mem_req, mem_we, retire, illegal_inst;
  logic [31:0] mem_addr, mem_wdata, pc;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
`ifdef MULTICYCLE_MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt;
`endif

  multicycle_mips_core #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC), .DATA_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .illegal_inst(illegal_inst)
`ifdef MULTICYCLE_MIPS_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [1024];
  logic [31:0] mMem [1024];
  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  logic        mIllegal;

  int          fixedWaits = 0;
  bit          randWaits = 0;
  int          retireCount = 0;
  int          cycCnt = 0, waitCnt = 0;
  bit          pcCheckPending = 0;
  int          latHist [256];
  logic [31:0] pcHist  [256];

  bit          inReq = 0, rdy = 0;
  int          reqCnt = 0, reqTarget = 0;
  logic [31:0] reqAddr, reqWdata;
  logic        reqWe;

  function automatic logic [31:0] rType(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iType(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jType(logic [5:0] op, logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]]  = word;
    mMem[addr[11:2]] = word;
  endtask

  task automatic wrReg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mRegs[r] = v;
  endtask

  // Executes one instruction at architectural level and reports its zero-wait latency.
  task automatic modelStep(output int base, output bit isSt, output logic [31:0] stAddr,
                           output logic [31:0] stData);
    logic [31:0] inst, pcPlus, a, b, simm, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    inst = mMem[mPc[11:2]];
    op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
    sh = inst[10:6];  fn = inst[5:0];
    a = mRegs[rs]; b = mRegs[rt];
    simm = {{16{inst[15]}}, inst[15:0]};
    pcPlus = mPc + 32'd4;
    mPc = pcPlus; base = 4; isSt = 0; stAddr = 0; stData = 0;
    case (op)
      6'h00: case (fn)
        6'h20: wrReg(rd, a + b);
        6'h22: wrReg(rd, a - b);
        6'h24: wrReg(rd, a & b);
        6'h25: wrReg(rd, a | b);
        6'h2A: wrReg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h00: wrReg(rd, b << sh);
        6'h02: wrReg(rd, b >> sh);
        6'h08: begin mPc = a; base = 2; end
        default: begin mIllegal = 1; base = 2; end
      endcase
      6'h02: begin mPc = {pcPlus[31:28], inst[25:0], 2'b00}; base = 2; end
      6'h03: begin wrReg(5'd31, pcPlus); mPc = {pcPlus[31:28], inst[25:0], 2'b00}; base = 2; end
      6'h08: wrReg(rt, a + simm);
      6'h23: begin ea = a + simm; wrReg(rt, mMem[ea[11:2]]); base = 5; end
      6'h2B: begin
        ea = a + simm; isSt = 1; stAddr = {ea[31:2], 2'b00}; stData = b;
        mMem[ea[11:2]] = b;
      end
      6'h04: begin base = 3; if (a == b) mPc = pcPlus + (simm << 2); end
      6'h05: begin base = 3; if (a != b) mPc = pcPlus + (simm << 2); end
      default: begin mIllegal = 1; base = 2; end
    endcase
  endtask

  // Memory responder and retire monitor share one process so ready and sampling stay ordered.
  initial begin
    int          base;
    bit          isSt;
    logic [31:0] stAddr, stData;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        mem_ready = 0; inReq = 0; cycCnt = 0; waitCnt = 0; pcCheckPending = 0;
      end else begin
        if (pcCheckPending) begin
          pcCheckPending = 0;
          if (retireCount <= 256) pcHist[retireCount-1] = pc;
          checks++;
          if (pc !== mPc) begin
            errors++; $display("[TB] FAIL pc_after_retire #%0d: got %h want %h", retireCount, pc, mPc);
          end
          checks++;
          if (illegal_inst !== mIllegal) begin
            errors++; $display("[TB] FAIL illegal_flag #%0d: got %b want %b", retireCount, illegal_inst, mIllegal);
          end
        end
        rdy = 0;
        if (mem_req) begin
          if (!inReq) begin
            inReq = 1; reqCnt = 0;
            reqTarget = randWaits ? int'($urandom_range(0, 2)) : fixedWaits;
            reqAddr = mem_addr; reqWe = mem_we; reqWdata = mem_wdata;
          end else begin
            checks++;
            if (mem_addr !== reqAddr || mem_we !== reqWe || (reqWe && mem_wdata !== reqWdata)) begin
              errors++;
              $display("[TB] FAIL hold_during_wait: got addr %h we %b wdata %h want addr %h we %b wdata %h",
                       mem_addr, mem_we, mem_wdata, reqAddr, reqWe, reqWdata);
            end
          end
          if (reqCnt == reqTarget) begin rdy = 1; inReq = 0; end
          else reqCnt++;
        end
        mem_ready = rdy;
        mem_rdata = rdy ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;
        if (rdy && mem_we) mem[mem_addr[11:2]] = mem_wdata;
        #1;
        cycCnt++;
        if (mem_req && !rdy) waitCnt++;
        if (retire) begin
          modelStep(base, isSt, stAddr, stData);
          if (retireCount < 256) latHist[retireCount] = cycCnt;
          retireCount++;
          checks++;
          if (cycCnt !== base + waitCnt) begin
            errors++; $display("[TB] FAIL latency #%0d: got %0d want %0d", retireCount, cycCnt, base + waitCnt);
          end
          checks++;
          if ((rdy && mem_we) !== isSt || (isSt && (mem_addr !== stAddr || mem_wdata !== stData))) begin
            errors++;
            $display("[TB] FAIL store #%0d: got we %b addr %h data %h want we %b addr %h data %h",
                     retireCount, rdy && mem_we, mem_addr, mem_wdata, isSt, stAddr, stData);
          end
          cycCnt = 0; waitCnt = 0; pcCheckPending = 1;
        end
      end
    end
  end

  task automatic enterReset();
    nrst = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; mMem[i] = 32'd0; end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mPc = RESET_PC; mIllegal = 0; retireCount = 0;
    @(posedge clk); #2;
    nrst = 1;
  endtask

  task automatic runRetires(input int n);
    int cyc = 0;
    while (retireCount < n && cyc < 5000) begin @(posedge clk); cyc++; end
    @(negedge clk); #3;
    checks++;
    if (retireCount < n) begin
      errors++; $display("[TB] FAIL retire_timeout: got %0d retires want %0d", retireCount, n);
    end
  endtask

  task automatic runUntilHalt(input logic [31:0] haltAddr);
    int cyc = 0;
    while (!(retireCount > 0 && mPc == haltAddr) && cyc < 20000) begin @(posedge clk); cyc++; end
    @(negedge clk); #3;
    checks++;
    if (mPc != haltAddr) begin
      errors++; $display("[TB] FAIL halt_timeout: got model pc %h want %h", mPc, haltAddr);
    end
  endtask

  task automatic test_reset();
    enterReset();
    put(32'h100, iType(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, iType(6'h2B, 5'd0, 5'd1, 16'h40));
    put(32'h108, jType(6'h02, 32'h108));
    checks++;
    if (pc !== RESET_PC || retire !== 1'b0 || illegal_inst !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state: got pc %h retire %b illegal %b want %h 0 0", pc, retire, illegal_inst, RESET_PC);
    end
    applyStimulus();
    @(negedge clk); #2;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RESET_PC) begin
      errors++; $display("[TB] FAIL first_fetch: got req %b we %b addr %h want 1 0 %h", mem_req, mem_we, mem_addr, RESET_PC);
    end
    runRetires(2);
    checks++;
    if (latHist[0] !== 4) begin
      errors++; $display("[TB] FAIL addi_latency: got %0d want 4", latHist[0]);
    end
    checks++;
    if (mem[16] !== 32'd5) begin
      errors++; $display("[TB] FAIL addi_result: got %h want 5", mem[16]);
    end
  endtask

  task automatic test_alu();
    enterReset();
    put(32'h100, iType(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, iType(6'h08, 5'd0, 5'd2, 16'd3));
    put(32'h108, rType(6'h22, 5'd2, 5'd1, 5'd3, 5'd0));
    put(32'h10C, rType(6'h2A, 5'd3, 5'd2, 5'd4, 5'd0));
    put(32'h110, rType(6'h20, 5'd1, 5'd1, 5'd0, 5'd0));
    put(32'h114, iType(6'h2B, 5'd0, 5'd3, 16'h40));
    put(32'h118, iType(6'h2B, 5'd0, 5'd4, 16'h44));
    put(32'h11C, iType(6'h2B, 5'd0, 5'd0, 16'h48));
    put(32'h120, jType(6'h02, 32'h120));
    mem[18] = 32'hFFFF_FFFF;
    applyStimulus();
    runUntilHalt(32'h120);
    checks++;
    if (mem[16] !== 32'hFFFF_FFFE) begin
      errors++; $display("[TB] FAIL sub_wrap: got %h want fffffffe", mem[16]);
    end
    checks++;
    if (mem[17] !== 32'd1) begin
      errors++; $display("[TB] FAIL slt_signed: got %h want 1", mem[17]);
    end
    checks++;
    if (mem[18] !== 32'd0) begin
      errors++; $display("[TB] FAIL reg0_write: got %h want 0", mem[18]);
    end
  endtask

  task automatic test_mem_waits();
    enterReset();
    fixedWaits = 2;
    put(32'h100, iType(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, iType(6'h2B, 5'd0, 5'd1, 16'h8));
    put(32'h108, iType(6'h23, 5'd0, 5'd5, 16'h8));
    put(32'h10C, iType(6'h2B, 5'd0, 5'd5, 16'h40));
    put(32'h110, jType(6'h02, 32'h110));
    applyStimulus();
    runUntilHalt(32'h110);
    fixedWaits = 0;
    checks++;
    if (mem[2] !== 32'd5 || mem[16] !== 32'd5) begin
      errors++; $display("[TB] FAIL sw_lw_data: got %h/%h want 5/5", mem[2], mem[16]);
    end
    checks++;
    if (latHist[2] !== 9) begin
      errors++; $display("[TB] FAIL lw_wait_latency: got %0d want 9", latHist[2]);
    end
  endtask

  task automatic test_branch_jump();
    enterReset();
    put(32'h100, iType(6'h08, 5'd0, 5'd1, 16'd1));
    put(32'h104, jType(6'h02, 32'h200));
    put(32'h200, iType(6'h04, 5'd1, 5'd1, 16'hFFFF));
    applyStimulus();
    runRetires(4);
    checks++;
    if (pcHist[2] !== 32'h200 || latHist[2] !== 3 || latHist[1] !== 2) begin
      errors++; $display("[TB] FAIL beq_taken: got pc %h lat %0d j lat %0d want 200 3 2", pcHist[2], latHist[2], latHist[1]);
    end
    enterReset();
    put(32'h100, jType(6'h02, 32'h200));
    put(32'h200, iType(6'h05, 5'd1, 5'd1, 16'd4));
    put(32'h204, jType(6'h02, 32'h300));
    put(32'h300, jType(6'h03, 32'h400));
    put(32'h400, rType(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));
    put(32'h304, iType(6'h2B, 5'd0, 5'd31, 16'h40));
    put(32'h308, jType(6'h02, 32'h308));
    applyStimulus();
    runUntilHalt(32'h308);
    checks++;
    if (pcHist[1] !== 32'h204) begin
      errors++; $display("[TB] FAIL bne_not_taken: got %h want 204", pcHist[1]);
    end
    checks++;
    if (pcHist[3] !== 32'h400 || pcHist[4] !== 32'h304 || latHist[4] !== 2) begin
      errors++; $display("[TB] FAIL jal_jr: got %h %h lat %0d want 400 304 2", pcHist[3], pcHist[4], latHist[4]);
    end
    checks++;
    if (mem[16] !== 32'h304) begin
      errors++; $display("[TB] FAIL jal_link: got %h want 304", mem[16]);
    end
  endtask

  task automatic test_illegal();
    enterReset();
    put(32'h100, {6'h3F, 26'd0});
    put(32'h104, iType(6'h08, 5'd0, 5'd1, 16'd9));
    put(32'h108, rType(6'h3F, 5'd1, 5'd1, 5'd2, 5'd0));
    put(32'h10C, iType(6'h2B, 5'd0, 5'd1, 16'h40));
    put(32'h110, jType(6'h02, 32'h110));
    applyStimulus();
    runRetires(1);
    checks++;
    if (illegal_inst !== 1'b1 || pcHist[0] !== 32'h104 || latHist[0] !== 2) begin
      errors++; $display("[TB] FAIL illegal_op: got flag %b pc %h lat %0d want 1 104 2", illegal_inst, pcHist[0], latHist[0]);
    end
    runUntilHalt(32'h110);
    checks++;
    if (illegal_inst !== 1'b1 || mem[16] !== 32'd9) begin
      errors++; $display("[TB] FAIL illegal_sticky: got flag %b data %h want 1 9", illegal_inst, mem[16]);
    end
  endtask

  task automatic test_reset_mid_store();
    bit found = 0;
    enterReset();
    fixedWaits = 5;
    put(32'h100, iType(6'h08, 5'd0, 5'd1, 16'h55));
    put(32'h104, iType(6'h2B, 5'd0, 5'd1, 16'h40));
    put(32'h108, jType(6'h02, 32'h108));
    mem[16] = 32'h1234_5678;
    applyStimulus();
    runRetires(1);
    for (int i = 0; i < 50 && !found; i++) begin
      if (mem_req && mem_we) found = 1;
      else begin @(negedge clk); #2; end
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL store_request_seen: got 0 want 1");
    end
    nrst = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem[16] !== 32'h1234_5678 || pc !== RESET_PC) begin
      errors++; $display("[TB] FAIL store_dropped: got mem %h pc %h want 12345678 %h", mem[16], pc, RESET_PC);
    end
    fixedWaits = 0;
    applyStimulus();
    @(negedge clk); #2;
    checks++;
    if (mem_addr !== RESET_PC || mem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL refetch_after_reset: got addr %h req %b want %h 1", mem_addr, mem_req, RESET_PC);
    end
    runUntilHalt(32'h108);
    checks++;
    if (mem[16] !== 32'h55) begin
      errors++; $display("[TB] FAIL store_after_rerun: got %h want 55", mem[16]);
    end
  endtask

  task automatic test_random(input int nBody);
    logic [31:0] a;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fns [7];
    int          bad = 0;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    enterReset();
    randWaits = 1;
    for (int i = 512; i < 576; i++) begin mem[i] = $urandom; mMem[i] = mem[i]; end
    a = RESET_PC;
    for (int r = 1; r < 8; r++) begin put(a, iType(6'h08, 5'd0, 5'(r), 16'($urandom))); a += 4; end
    for (int k = 0; k < nBody; k++) begin
      int sel = int'($urandom_range(0, 11));
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      if (sel < 7)       put(a, rType(fns[sel], rs, rt, rd, 5'($urandom)));
      else if (sel == 7) put(a, iType(6'h08, rs, rt, 16'($urandom)));
      else if (sel == 8) put(a, iType(6'h23, 5'd0, rt, 16'(32'h800 + $urandom_range(0, 255))));
      else if (sel == 9) put(a, iType(6'h2B, 5'd0, rt, 16'(32'h800 + $urandom_range(0, 255))));
      else               put(a, iType((sel == 10) ? 6'h04 : 6'h05, rs, rt, 16'($urandom_range(0, 2))));
      a += 4;
    end
    for (int r = 1; r < 8; r++) begin put(a, iType(6'h2B, 5'd0, 5'(r), 16'(32'h900 + 4 * r))); a += 4; end
    put(a, jType(6'h02, a));
    applyStimulus();
    runUntilHalt(a);
    randWaits = 0;
    for (int i = 512; i < 584; i++) if (mem[i] !== mMem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL random_memory_image: got %0d differing words want 0", bad);
    end
  endtask

`ifdef MULTICYCLE_MIPS_PERF_CNT_EN
  task automatic test_perf_counters();
    enterReset();
    for (int i = 0; i < 3; i++) put(RESET_PC + 32'(4 * i), rType(6'h20, 5'd0, 5'd0, 5'd1, 5'd0));
    put(RESET_PC + 32'd12, jType(6'h02, RESET_PC + 32'd12));
    applyStimulus();
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (retire_cnt !== 32'd3 || cycle_cnt !== 32'd12 || stall_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_counters: got ret %0d cyc %0d stall %0d want 3 12 0", retire_cnt, cycle_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mem_waits();
    test_branch_jump();
    test_illegal();
    test_reset_mid_store();
    for (int s = 0; s < 3; s++) test_random(40);
`ifdef MULTICYCLE_MIPS_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
